uart_tx_feeder: RTL

Byte queue and launch sequencer sitting directly upstream of the UART transmitter. The core's output path pushes bytes at full clock rate. This block buffers them in a FIFO and hands them one at a time to the transmitter over its `sdata`/`tx_start`/`tx_busy` handshake, so the CPU stalls only when the queue is full.

---
 rtl/uart_tx_feeder.sv | 109 ++++++++++
 1 files changed

// File: rtl/uart_tx_feeder.sv
// Byte FIFO in front of the UART transmitter. It queues bytes written at full clock
// rate and launches them one at a time over the sdata/tx_start/tx_busy handshake.
module uart_tx_feeder #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  wr_en,
   input  logic [7:0]            wr_data,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  overflow,
   output logic                  all_sent,
   output logic [7:0]            sdata,
   output logic                  tx_start,
   input  logic                  tx_busy
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT_ACK,
      S_WAIT_DONE
   } state_t;

   state_t state;
   state_t state_next;

   logic [7:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wptr;
   logic [DEPTH_LOG2-1:0] rptr;
   logic                  wr_accept;
   logic                  pop;

   assign full      = (count == FULL_COUNT);
   assign empty     = (count == '0);
   assign wr_accept = wr_en & ~full;
   assign pop       = (state == S_IDLE) & ~empty & ~tx_busy;
   assign all_sent  = empty & (state == S_IDLE) & ~tx_busy;

   // Storage is left unreset; stale entries are unreachable once the pointers clear.
   always_ff @(posedge clk) begin
      if (wr_accept) begin
         mem[wptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= S_IDLE;
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         overflow <= 1'b0;
         sdata    <= 8'h00;
         tx_start <= 1'b0;
      end else begin
         state    <= state_next;
         tx_start <= pop;
         if (wr_accept) begin
            wptr <= wptr + 1'b1;
         end
         if (wr_en && full) begin
            overflow <= 1'b1;
         end
         if (pop) begin
            sdata <= mem[rptr];
            rptr  <= rptr + 1'b1;
         end
         if (wr_accept && !pop) begin
            count <= count + 1'b1;
         end else if (!wr_accept && pop) begin
            count <= count - 1'b1;
         end
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         S_IDLE: begin
            if (pop) begin
               state_next = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            state_next = S_WAIT_ACK;
         end
         S_WAIT_ACK: begin
            if (tx_busy) begin
               state_next = S_WAIT_DONE;
            end
         end
         S_WAIT_DONE: begin
            if (!tx_busy) begin
               state_next = S_IDLE;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

endmodule
